// File: rtl/fifo_reader.sv
// fifo_reader
//   Read-side controller that drains a FIFO with a 1-cycle registered read port
//   onto a valid/ready stream. A 3-entry skid buffer absorbs the read latency,
//   so one word per cycle can be sustained while the FIFO is never underflowed.
//
// Ports
//   clk_i         in   clock, rising edge
//   rst_ni        in   synchronous active-low reset
//   en_i          in   1: new FIFO reads allowed; 0: stop reading, keep draining
//   fifo_empty_i  in   FIFO empty flag (combinational from FIFO pointers)
//   fifo_data_i   in   FIFO read data, valid the cycle after fifo_rd_en_o
//   fifo_rd_en_o  out  FIFO read strobe
//   valid_o       out  data_o holds a word
//   ready_i       in   sink accepts the word this cycle
//   data_o        out  head word of the skid buffer
//   idle_o        out  buffer empty and no read in flight
//   xfer_cnt_o    out  accepted-word count, wraps modulo 2**CNT_WIDTH
module fifo_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_rd_en_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  idle_o,
  output logic [CNT_WIDTH-1:0]  xfer_cnt_o
);

  localparam int DEPTH = 3;

  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic [1:0]            r_head;
  logic [1:0]            r_tail;
  logic [CNT_WIDTH-1:0]  r_xfer_cnt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [2:0]            w_level;
  logic                  w_pop;
  logic [1:0]            w_head_next;
  logic [1:0]            w_tail_next;

  // Entries already buffered plus the word still coming out of the FIFO.
  // Reading only while this is below the depth guarantees a free slot.
  assign w_level = {1'b0, r_occ} + {2'b00, r_inflight};

  // Depends only on registered state and FIFO flags; ready_i is not involved.
  assign fifo_rd_en_o = rst_ni & en_i & ~fifo_empty_i & (w_level < 3'd3);

  assign valid_o    = (r_occ != 2'd0);
  assign data_o     = r_mem[r_head];
  assign idle_o     = (r_occ == 2'd0) & ~r_inflight;
  assign xfer_cnt_o = r_xfer_cnt;
  assign w_pop      = valid_o & ready_i;

  // Pointers wrap 2 -> 0 for the 3-entry ring.
  assign w_head_next = (r_head == 2'd2) ? 2'd0 : r_head + 2'd1;
  assign w_tail_next = (r_tail == 2'd2) ? 2'd0 : r_tail + 2'd1;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_head     <= 2'd0;
      r_tail     <= 2'd0;
      r_xfer_cnt <= '0;
    end else begin
      r_inflight <= fifo_rd_en_o;
      // Capture and pop in the same cycle leave occupancy unchanged.
      r_occ      <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
      if (r_inflight) begin
        r_tail <= w_tail_next;
      end
      if (w_pop) begin
        r_head     <= w_head_next;
        r_xfer_cnt <= r_xfer_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // One register per buffer slot; cleared on reset so data_o reads 0 afterwards.
  // A word arriving during reset is simply not captured.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          r_mem[gi] <= '0;
        end else if (r_inflight && (r_tail == 2'(gi))) begin
          r_mem[gi] <= fifo_data_i;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_fifo_reader.sv
module tb_fifo_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       rd_en;
  logic       valid;
  logic       ready;
  logic [7:0] data;
  logic       idle;
  logic [3:0] xfer_cnt;

  logic       fifo_rst_n;
  logic       underflow;
  logic [7:0] fifo_q [$];
  logic [7:0] exp_q  [$];
  logic [3:0] m_cnt;
  logic       mon_on;
  logic       prev_hold;
  logic [7:0] prev_data;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  fifo_reader #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .en_i         (en),
    .fifo_empty_i (fifo_empty),
    .fifo_data_i  (fifo_data),
    .fifo_rd_en_o (rd_en),
    .valid_o      (valid),
    .ready_i      (ready),
    .data_o       (data),
    .idle_o       (idle),
    .xfer_cnt_o   (xfer_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // FIFO model: registered read data, combinational empty flag.
  always @(posedge clk) begin
    if (!fifo_rst_n) begin
      fifo_q.delete();
      fifo_empty <= 1'b1;
      fifo_data  <= 8'h00;
    end else if (rd_en) begin
      if (fifo_q.size() == 0) begin
        underflow <= 1'b1;
      end else begin
        fifo_data  <= fifo_q.pop_front();
        fifo_empty <= (fifo_q.size() == 0);
      end
    end
  end

  // Output monitor: scoreboard pop, count model, hold-stability, no-underflow.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("xfer_cnt", xfer_cnt, m_cnt);
      chk("rd_when_empty", rd_en & fifo_empty, 0);
      if (rst_n && prev_hold) begin
        chk("hold_valid", valid, 1);
        chk("hold_data", data, prev_data);
      end
      if (!rst_n) begin
        m_cnt = 4'd0;
      end else if (valid && ready) begin
        if (exp_q.size() == 0) chk("sb_unexpected", data, 8'hFF);
        else begin
          chk("sb_data", data, exp_q[0]);
          $display("word out %02h", data);
          void'(exp_q.pop_front());
        end
        m_cnt = m_cnt + 4'd1;
      end
      prev_hold = rst_n & valid & ~ready;
      prev_data = data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic drain(input int lim);
    int n = 0;
    @(negedge clk);
    while (!(fifo_q.size() == 0 && idle && !rd_en) && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (n >= lim) chk("drain_timeout", n, 0);
  endtask

  initial begin
    int n;
    rst_n = 0; fifo_rst_n = 0; en = 0; ready = 0;
    underflow = 0; m_cnt = 0; mon_on = 0; prev_hold = 0; prev_data = 0;
    fifo_empty = 1; fifo_data = 0;

    // 1: reset held two cycles with two words waiting in the FIFO
    step();
    fifo_rst_n = 1;
    push_word(8'h11);
    push_word(8'h22);
    step();
    step();
    @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_idle", idle, 1);
    chk("rst_cnt", xfer_cnt, 0);
    chk("rst_data", data, 0);
    mon_on = 1;
    step();
    rst_n = 1; en = 1; ready = 1;
    drain(20);

    // 2: first-word latency
    step();
    push_word(8'hA5);
    @(negedge clk); chk("lat_rd_en_T", rd_en, 1);
    @(negedge clk); chk("lat_valid_T1", valid, 0);
    @(negedge clk); chk("lat_valid_T2", valid, 1); chk("lat_data_T2", data, 8'hA5);
    @(negedge clk); chk("lat_cnt_T3", xfer_cnt, 3);
    drain(20);

    // 3: sustained throughput, 8 back-to-back words
    step();
    for (int i = 1; i <= 8; i++) push_word(8'(i));
    n = 0;
    @(negedge clk);
    while (!valid && n < 10) begin @(negedge clk); n++; end
    chk("thru_start", valid, 1);
    for (int i = 0; i < 8; i++) begin
      chk("thru_valid", valid, 1);
      @(negedge clk);
    end
    drain(20);

    // 4: backpressure then release
    step();
    ready = 0;
    for (int i = 1; i <= 4; i++) push_word(8'(i));
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n += int'(rd_en);
    end
    chk("bp_rd_pulses", n, 3);
    chk("bp_valid", valid, 1);
    chk("bp_data", data, 8'h01);
    step();
    ready = 1;
    @(negedge clk); chk("bp_rd_still_off", rd_en, 0);
    @(negedge clk); chk("bp_rd_resume", rd_en, 1);
    drain(20);

    // 5: disable right after a read; that word still comes out
    step();
    push_word(8'h77);
    @(negedge clk); chk("en_rd_en", rd_en, 1);
    step();
    en = 0;
    push_word(8'h88);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n += int'(rd_en);
    end
    chk("en_no_reads", n, 0);
    chk("en_idle", idle, 1);
    chk("en_sb_left", exp_q.size(), 1);
    step();
    en = 1;
    drain(20);

    // 6: reset with occ=2 and a read in flight; FIFO reset too
    step();
    ready = 0;
    for (int i = 1; i <= 4; i++) push_word(8'h30 + 8'(i));
    n = 0;
    for (int i = 0; i < 10 && n < 3; i++) begin
      @(negedge clk);
      n += int'(rd_en);
    end
    chk("mid_rd_pulses", n, 3);
    step();
    rst_n = 0; fifo_rst_n = 0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    chk("mid_valid", valid, 0);
    chk("mid_idle", idle, 1);
    step();
    rst_n = 1; fifo_rst_n = 1; ready = 1;
    push_word(8'h55);
    push_word(8'h66);
    drain(20);

    // counter wrap at 4 bits: 16 pops after reset return to 0
    step();
    rst_n = 0;
    step();
    rst_n = 1;
    for (int i = 0; i < 16; i++) push_word(8'h40 + 8'(i));
    drain(40);
    chk("cnt_wrap", xfer_cnt, 0);

    chk("sb_leftover", exp_q.size(), 0);
    chk("fifo_underflow", underflow, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
